// File: rtl/arms_counter_sequencer.sv
// Command-side sequencer for the ARMS counter strobe interface: issues reset/load/enable
// commands on STRB/CON/DATA, then waits for COUT to reach the requested limit or a timeout.
module arms_counter_sequencer #(
    parameter int SETUP_CYC = 1,
    parameter int HIGH_CYC  = 2,
    parameter int LOW_CYC   = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic [3:0] REQ_LIM,
    input  logic       REQ_DIR,
    output logic       STRB,
    output logic [1:0] CON,
    output logic [3:0] DATA,
    input  logic [3:0] COUT,
    output logic       BUSY,
    output logic       DONE,
    output logic       TMO
);

    localparam int MAX_AB = (SETUP_CYC > HIGH_CYC) ? SETUP_CYC : HIGH_CYC;
    localparam int MAXC   = (MAX_AB > LOW_CYC) ? MAX_AB : LOW_CYC;
    localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_WAIT
    } stateT;

    stateT         state, stateNext;
    logic [CW-1:0] cnt, cntNext;
    logic [1:0]    cmd, cmdNext;
    logic [3:0]    limR, limNext;
    logic          dirR, dirNext;
    logic [1:0]    conR, conNext;
    logic [3:0]    dataR, dataNext;
    logic          strbR, strbNext;
    logic          doneR, doneNext;
    logic          tmoR, tmoNext;
    logic [7:0]    tmoCnt, tmoCntNext;
    logic [3:0]    coutR;
    logic          match;

    assign match = (coutR == limR);

    // Phase timing per command plus the WAIT-phase compare/timeout decision.
    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        cmdNext    = cmd;
        limNext    = limR;
        dirNext    = dirR;
        conNext    = conR;
        dataNext   = dataR;
        tmoCntNext = tmoCnt;
        doneNext   = 1'b0;
        tmoNext    = 1'b0;
        case (state)
            S_IDLE: begin
                if (REQ_VALID) begin
                    stateNext = S_SETUP;
                    cntNext   = '0;
                    cmdNext   = 2'd0;
                    limNext   = REQ_LIM;
                    dirNext   = REQ_DIR;
                    conNext   = 2'b00;
                    dataNext  = 4'd0;
                end
            end
            S_SETUP: begin
                if (cnt == CW'(SETUP_CYC - 1)) begin
                    stateNext = S_HIGH;
                    cntNext   = '0;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            S_HIGH: begin
                if (cnt == CW'(HIGH_CYC - 1)) begin
                    stateNext = S_LOW;
                    cntNext   = '0;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            S_LOW: begin
                if (cnt == CW'(LOW_CYC - 1)) begin
                    cntNext = '0;
                    if (cmd == 2'd2) begin
                        stateNext  = S_WAIT;
                        tmoCntNext = 8'd0;
                    end else begin
                        // CON/DATA for the next command change only on SETUP entry
                        stateNext = S_SETUP;
                        cmdNext   = cmd + 2'd1;
                        conNext   = (cmd == 2'd0) ? 2'b01 : {1'b1, dirR};
                        dataNext  = (cmd == 2'd0) ? limR : 4'd0;
                    end
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            S_WAIT: begin
                if (match) begin
                    stateNext = S_IDLE;
                    doneNext  = 1'b1;
                end else if (tmoCnt == 8'(TIMEOUT - 1)) begin
                    stateNext = S_IDLE;
                    doneNext  = 1'b1;
                    tmoNext   = 1'b1;
                end else begin
                    tmoCntNext = tmoCnt + 8'd1;
                end
            end
            default: stateNext = S_IDLE;
        endcase
        strbNext = (stateNext == S_HIGH);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IDLE;
            cnt    <= '0;
            cmd    <= 2'd0;
            limR   <= 4'd0;
            dirR   <= 1'b0;
            conR   <= 2'b00;
            dataR  <= 4'd0;
            strbR  <= 1'b0;
            doneR  <= 1'b0;
            tmoR   <= 1'b0;
            tmoCnt <= 8'd0;
            coutR  <= 4'd0;
        end else begin
            state  <= stateNext;
            cnt    <= cntNext;
            cmd    <= cmdNext;
            limR   <= limNext;
            dirR   <= dirNext;
            conR   <= conNext;
            dataR  <= dataNext;
            strbR  <= strbNext;
            doneR  <= doneNext;
            tmoR   <= tmoNext;
            tmoCnt <= tmoCntNext;
            coutR  <= COUT;
        end
    end

    assign REQ_READY = (state == S_IDLE);
    assign BUSY      = ~REQ_READY;
    assign STRB      = strbR;
    assign CON       = conR;
    assign DATA      = dataR;
    assign DONE      = doneR;
    assign TMO       = tmoR;

endmodule
